// File: rtl/uart_cfg.sv
// uart_cfg: full-duplex UART with a shared 16x oversampling baud generator.
// Optional parity bit when the macro UART_PARITY_EN is defined.
module uart_cfg #(
   parameter int NB_DATA = 8,
   parameter int SB_TICK = 16,
   parameter int DVSR    = 163,
   parameter int NB_DVSR = 8
`ifdef UART_PARITY_EN
   ,
   parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx,
   input  logic               i_tx_start,
   input  logic [NB_DATA-1:0] i_tx,
   output logic               o_tx,
   output logic               o_tx_done_tick,
   output logic               o_tx_busy,
   output logic [NB_DATA-1:0] o_rx,
   output logic               o_rx_done_tick,
   output logic               o_frame_err,
   output logic               o_parity_err
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
`ifdef UART_PARITY_EN
      ST_PARITY,
`endif
      ST_STOP
   } state_e;

   localparam logic [NB_DVSR-1:0] DVSR_LAST = NB_DVSR'(DVSR - 1);
   localparam logic [4:0]         TICK_MID  = 5'd7;
   localparam logic [4:0]         TICK_BIT  = 5'd15;
   localparam logic [4:0]         STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [3:0]         BIT_LAST  = 4'(NB_DATA - 1);

   logic [NB_DVSR-1:0] baud_cnt_q, baud_cnt_d;
   logic               tick;

   logic               rx_meta_q, rx_sync_q;
   state_e             rx_state_q, rx_state_d;
   logic [4:0]         rx_s_q, rx_s_d;
   logic [3:0]         rx_n_q, rx_n_d;
   logic [NB_DATA-1:0] rx_b_q, rx_b_d;
   logic               rx_armed_q, rx_armed_d;
   logic [NB_DATA-1:0] rx_data_q, rx_data_d;
   logic               rx_done_q, rx_done_d;
   logic               frame_err_q, frame_err_d;

   state_e             tx_state_q, tx_state_d;
   logic [4:0]         tx_s_q, tx_s_d;
   logic [3:0]         tx_n_q, tx_n_d;
   logic [NB_DATA-1:0] tx_b_q, tx_b_d;
   logic               tx_line_q, tx_line_d;
   logic               tx_busy_q, tx_busy_d;
   logic               tx_done_q, tx_done_d;

`ifdef UART_PARITY_EN
   logic               rx_par_q, rx_par_d;
   logic               parity_err_q, parity_err_d;
   logic               tx_par_q, tx_par_d;
`endif

   always_comb begin
      tick       = (baud_cnt_q == DVSR_LAST);
      baud_cnt_d = tick ? '0 : baud_cnt_q + NB_DVSR'(1);
   end

   // RX re-arms only after the synchronized line has been seen high, so a
   // stuck-low line after a framing error or reset cannot start a frame.
   always_comb begin
      // NOTE: every signal gets a default before the case so no latch is inferred.
      rx_state_d  = rx_state_q;
      rx_s_d      = rx_s_q;
      rx_n_d      = rx_n_q;
      rx_b_d      = rx_b_q;
      rx_armed_d  = rx_armed_q | rx_sync_q;
      rx_data_d   = rx_data_q;
      rx_done_d   = 1'b0;
      frame_err_d = frame_err_q;
`ifdef UART_PARITY_EN
      rx_par_d     = rx_par_q;
      parity_err_d = parity_err_q;
`endif
      case (rx_state_q)
         ST_IDLE: begin
            if (rx_armed_q && !rx_sync_q) begin
               rx_state_d = ST_START;
               rx_s_d     = '0;
            end
         end
         ST_START: begin
            if (tick) begin
               if (rx_s_q == TICK_MID) begin
                  if (rx_sync_q) begin
                     rx_state_d = ST_IDLE;
                  end else begin
                     rx_state_d = ST_DATA;
                     rx_s_d     = '0;
                     rx_n_d     = '0;
                  end
               end else begin
                  rx_s_d = rx_s_q + 5'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (rx_s_q == TICK_BIT) begin
                  rx_s_d = '0;
                  rx_b_d = {rx_sync_q, rx_b_q[NB_DATA-1:1]};
                  if (rx_n_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                     rx_state_d = ST_PARITY;
`else
                     rx_state_d = ST_STOP;
`endif
                  end else begin
                     rx_n_d = rx_n_q + 4'd1;
                  end
               end else begin
                  rx_s_d = rx_s_q + 5'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               if (rx_s_q == TICK_BIT) begin
                  rx_s_d     = '0;
                  rx_par_d   = rx_sync_q;
                  rx_state_d = ST_STOP;
               end else begin
                  rx_s_d = rx_s_q + 5'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (rx_s_q == STOP_LAST) begin
                  rx_state_d  = ST_IDLE;
                  rx_data_d   = rx_b_q;
                  rx_done_d   = 1'b1;
                  frame_err_d = !rx_sync_q;
`ifdef UART_PARITY_EN
                  parity_err_d = ((^rx_b_q) ^ rx_par_q) != PARITY_ODD;
`endif
                  if (!rx_sync_q) rx_armed_d = 1'b0;
               end else begin
                  rx_s_d = rx_s_q + 5'd1;
               end
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   // The line level is registered from the next state so each bit starts on
   // the same edge that consumes the previous bit's last tick.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_s_d     = tx_s_q;
      tx_n_d     = tx_n_q;
      tx_b_d     = tx_b_q;
      tx_done_d  = 1'b0;
`ifdef UART_PARITY_EN
      tx_par_d   = tx_par_q;
`endif
      case (tx_state_q)
         ST_IDLE: begin
            if (i_tx_start && !tx_done_q) begin
               tx_state_d = ST_START;
               tx_s_d     = '0;
               tx_b_d     = i_tx;
`ifdef UART_PARITY_EN
               tx_par_d   = (^i_tx) ^ PARITY_ODD;
`endif
            end
         end
         ST_START: begin
            if (tick) begin
               if (tx_s_q == TICK_BIT) begin
                  tx_state_d = ST_DATA;
                  tx_s_d     = '0;
                  tx_n_d     = '0;
               end else begin
                  tx_s_d = tx_s_q + 5'd1;
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (tx_s_q == TICK_BIT) begin
                  tx_s_d = '0;
                  tx_b_d = {1'b0, tx_b_q[NB_DATA-1:1]};
                  if (tx_n_q == BIT_LAST) begin
`ifdef UART_PARITY_EN
                     tx_state_d = ST_PARITY;
`else
                     tx_state_d = ST_STOP;
`endif
                  end else begin
                     tx_n_d = tx_n_q + 4'd1;
                  end
               end else begin
                  tx_s_d = tx_s_q + 5'd1;
               end
            end
         end
`ifdef UART_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               if (tx_s_q == TICK_BIT) begin
                  tx_s_d     = '0;
                  tx_state_d = ST_STOP;
               end else begin
                  tx_s_d = tx_s_q + 5'd1;
               end
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               if (tx_s_q == STOP_LAST) begin
                  tx_state_d = ST_IDLE;
                  tx_done_d  = 1'b1;
               end else begin
                  tx_s_d = tx_s_q + 5'd1;
               end
            end
         end
         default: tx_state_d = ST_IDLE;
      endcase

      case (tx_state_d)
         ST_START:  tx_line_d = 1'b0;
         ST_DATA:   tx_line_d = tx_b_d[0];
`ifdef UART_PARITY_EN
         ST_PARITY: tx_line_d = tx_par_d;
`endif
         default:   tx_line_d = 1'b1;
      endcase
      tx_busy_d = (tx_state_d != ST_IDLE) || tx_done_d;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         baud_cnt_q  <= '0;
         rx_meta_q   <= 1'b1;
         rx_sync_q   <= 1'b1;
         rx_state_q  <= ST_IDLE;
         rx_s_q      <= '0;
         rx_n_q      <= '0;
         rx_b_q      <= '0;
         rx_armed_q  <= 1'b0;
         rx_data_q   <= '0;
         rx_done_q   <= 1'b0;
         frame_err_q <= 1'b0;
         tx_state_q  <= ST_IDLE;
         tx_s_q      <= '0;
         tx_n_q      <= '0;
         tx_b_q      <= '0;
         tx_line_q   <= 1'b1;
         tx_busy_q   <= 1'b0;
         tx_done_q   <= 1'b0;
`ifdef UART_PARITY_EN
         rx_par_q     <= 1'b0;
         parity_err_q <= 1'b0;
         tx_par_q     <= 1'b0;
`endif
      end else begin
         baud_cnt_q  <= baud_cnt_d;
         rx_meta_q   <= i_rx;
         rx_sync_q   <= rx_meta_q;
         rx_state_q  <= rx_state_d;
         rx_s_q      <= rx_s_d;
         rx_n_q      <= rx_n_d;
         rx_b_q      <= rx_b_d;
         rx_armed_q  <= rx_armed_d;
         rx_data_q   <= rx_data_d;
         rx_done_q   <= rx_done_d;
         frame_err_q <= frame_err_d;
         tx_state_q  <= tx_state_d;
         tx_s_q      <= tx_s_d;
         tx_n_q      <= tx_n_d;
         tx_b_q      <= tx_b_d;
         tx_line_q   <= tx_line_d;
         tx_busy_q   <= tx_busy_d;
         tx_done_q   <= tx_done_d;
`ifdef UART_PARITY_EN
         rx_par_q     <= rx_par_d;
         parity_err_q <= parity_err_d;
         tx_par_q     <= tx_par_d;
`endif
      end
   end

   assign o_tx           = tx_line_q;
   assign o_tx_done_tick = tx_done_q;
   assign o_tx_busy      = tx_busy_q;
   assign o_rx           = rx_data_q;
   assign o_rx_done_tick = rx_done_q;
   assign o_frame_err    = frame_err_q;
`ifdef UART_PARITY_EN
   assign o_parity_err   = parity_err_q;
`else
   assign o_parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cfg.sv
// Self-checking bench for uart_cfg: tick-level TX line model, RX scoreboard,
// and directed vectors (loopback, glitch, framing error, parity, reset).
module tb_uart_cfg;

   localparam int NB      = 8;
   localparam int SB      = 16;
   localparam int DV      = 2;
   localparam int BIT_CYC = 16 * DV;
`ifdef UART_PARITY_EN
   localparam bit TB_ODD   = 1'b0;
   localparam int PAR_BITS = 1;
   localparam int BUSY_MIN = 352;
`else
   localparam int PAR_BITS = 0;
   localparam int BUSY_MIN = 320;
`endif
   localparam int TX_TICKS = 16 + 16 * NB + 16 * PAR_BITS + SB;

   typedef struct {
      logic [NB-1:0] data;
      logic          fe;
      logic          pe;
   } rx_exp_t;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b1;
   logic          rx_drv   = 1'b1;
   logic          loop_en  = 1'b0;
   logic          tx_start = 1'b0;
   logic [NB-1:0] tx_data  = '0;
   logic          rx_line;
   logic          o_tx, o_tx_done_tick, o_tx_busy;
   logic [NB-1:0] o_rx;
   logic          o_rx_done_tick, o_frame_err, o_parity_err;

   assign rx_line = loop_en ? o_tx : rx_drv;

   uart_cfg #(
      .NB_DATA(NB),
      .SB_TICK(SB),
      .DVSR(DV),
      .NB_DVSR(8)
`ifdef UART_PARITY_EN
      ,
      .PARITY_ODD(TB_ODD)
`endif
   ) dut (
      .i_clk(clk),
      .i_reset(rst_n),
      .i_rx(rx_line),
      .i_tx_start(tx_start),
      .i_tx(tx_data),
      .o_tx(o_tx),
      .o_tx_done_tick(o_tx_done_tick),
      .o_tx_busy(o_tx_busy),
      .o_rx(o_rx),
      .o_rx_done_tick(o_rx_done_tick),
      .o_frame_err(o_frame_err),
      .o_parity_err(o_parity_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: tick phase from edges since reset, TX progress in ticks,
   // and a queue of words the receiver must still deliver.
   int            edge_n      = 0;
   bit            m_tick      = 1'b0;
   bit            m_prev_done = 1'b0;
   bit            m_tx_active = 1'b0;
   int            m_t         = 0;
   logic [NB-1:0] m_word      = '0;
   bit            exp_done    = 1'b0;
   rx_exp_t       m_rx_q[$];
   rx_exp_t       m_e;
   logic [NB-1:0] m_rx_last   = '0;
   logic          m_fe_last   = 1'b0;
   logic          m_pe_last   = 1'b0;

   function automatic logic exp_line();
      if (!m_tx_active)              return 1'b1;
      if (m_t < 16)                  return 1'b0;
      if (m_t < 16 + 16 * NB)        return m_word[(m_t - 16) / 16];
`ifdef UART_PARITY_EN
      if (m_t < 16 + 16 * (NB + 1))  return (^m_word) ^ TB_ODD;
`endif
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_n      = 0;
         m_tx_active = 1'b0;
         m_t         = 0;
         exp_done    = 1'b0;
         m_rx_q.delete();
         m_rx_last   = '0;
         m_fe_last   = 1'b0;
         m_pe_last   = 1'b0;
      end else begin
         edge_n++;
         m_tick      = (edge_n % DV == 0);
         m_prev_done = exp_done;
         exp_done    = 1'b0;
         if (m_tx_active) begin
            if (m_tick) begin
               m_t++;
               if (m_t == TX_TICKS) begin
                  m_tx_active = 1'b0;
                  exp_done    = 1'b1;
               end
            end
         end else if (!m_prev_done && tx_start) begin
            m_tx_active = 1'b1;
            m_t         = 0;
            m_word      = tx_data;
            if (loop_en) begin
               m_e = '{data: tx_data, fe: 1'b0, pe: 1'b0};
               m_rx_q.push_back(m_e);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("o_tx", o_tx, exp_line());
         check("o_tx_busy", o_tx_busy, m_tx_active || exp_done);
         check("o_tx_done_tick", o_tx_done_tick, exp_done);
         if (m_rx_q.size() == 0) begin
            check("rx_done_unexpected", o_rx_done_tick, 1'b0);
         end else if (o_rx_done_tick) begin
            m_e       = m_rx_q.pop_front();
            m_rx_last = m_e.data;
            m_fe_last = m_e.fe;
            m_pe_last = m_e.pe;
         end
         check("o_rx", o_rx, m_rx_last);
         check("o_frame_err", o_frame_err, m_fe_last);
         check("o_parity_err", o_parity_err, m_pe_last);
      end
   end

   int tx_done_cnt = 0;
   int rx_done_cnt = 0;
   int busy_cnt    = 0;
   always @(negedge clk) begin
      tx_done_cnt += int'(o_tx_done_tick);
      rx_done_cnt += int'(o_rx_done_tick);
      busy_cnt    += int'(o_tx_busy);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_send(input logic [NB-1:0] w);
      tx_data  = w;
      tx_start = 1'b1;
      step(1);
      tx_start = 1'b0;
   endtask

   task automatic wait_tx_done(input string name);
      int k = 0;
      while (o_tx_done_tick !== 1'b1 && k < 2000) begin
         step(1);
         k++;
      end
      check(name, o_tx_done_tick, 1'b1);
   endtask

   task automatic wait_rx_done(input string name);
      int k = 0;
      while (o_rx_done_tick !== 1'b1 && k < 2000) begin
         step(1);
         k++;
      end
      check(name, o_rx_done_tick, 1'b1);
   endtask

   task automatic send_frame(input logic [NB-1:0] w, input logic stop_bit, input logic flip_par);
      rx_exp_t e;
      e = '{data: w, fe: !stop_bit, pe: (PAR_BITS != 0) ? flip_par : 1'b0};
      m_rx_q.push_back(e);
      rx_drv = 1'b0;
      step(BIT_CYC);
      for (int i = 0; i < NB; i++) begin
         rx_drv = w[i];
         step(BIT_CYC);
      end
`ifdef UART_PARITY_EN
      rx_drv = (^w) ^ TB_ODD ^ flip_par;
      step(BIT_CYC);
`endif
      rx_drv = stop_bit;
      step(BIT_CYC);
      if (!stop_bit) step(2 * BIT_CYC);
      rx_drv = 1'b1;
      step(2 * BIT_CYC);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int tx_cnt0, rx_cnt0;
      #3;
      rst_n    = 1'b0;
      check_en = 1'b1;
      step(2);
      check("reset o_tx", o_tx, 1'b1);
      check("reset o_tx_busy", o_tx_busy, 1'b0);
      check("reset o_tx_done_tick", o_tx_done_tick, 1'b0);
      check("reset o_rx", o_rx, 8'h00);
      check("reset o_rx_done_tick", o_rx_done_tick, 1'b0);
      check("reset o_frame_err", o_frame_err, 1'b0);
      rst_n = 1'b1;
      step(4);

      // Loopback E5, with 3C requested mid-frame and dropped.
      loop_en  = 1'b1;
      step(2);
      busy_cnt = 0;
      tx_cnt0  = tx_done_cnt;
      rx_cnt0  = rx_done_cnt;
      tx_send(8'hE5);
      step(40);
      check("busy before 3C", o_tx_busy, 1'b1);
      tx_send(8'h3C);
      check("busy after 3C", o_tx_busy, 1'b1);
      wait_rx_done("rx done E5");
      check("rx E5", o_rx, 8'hE5);
      check("rx E5 frame_err", o_frame_err, 1'b0);
      check("rx E5 parity_err", o_parity_err, 1'b0);
      wait_tx_done("tx done E5");
      step(100);
      check("tx done count E5", tx_done_cnt - tx_cnt0, 1);
      check("rx done count E5", rx_done_cnt - rx_cnt0, 1);
      check("busy length E5", (busy_cnt >= BUSY_MIN && busy_cnt <= BUSY_MIN + 1), 1'b1);

      // Start during the done cycle is dropped; next cycle is accepted.
      tx_send(8'h96);
      wait_rx_done("rx done 96");
      check("rx 96", o_rx, 8'h96);
      wait_tx_done("tx done 96");
      tx_data  = 8'h11;
      tx_start = 1'b1;
      step(1);
      check("start in done cycle ignored", o_tx_busy, 1'b0);
      tx_data = 8'h4B;
      step(1);
      tx_start = 1'b0;
      check("start after done accepted", o_tx_busy, 1'b1);
      wait_rx_done("rx done 4B");
      check("rx 4B", o_rx, 8'h4B);
      wait_tx_done("tx done 4B");
      step(10);

      // Short low glitch on an idle line.
      loop_en = 1'b0;
      rx_drv  = 1'b1;
      step(10);
      rx_cnt0 = rx_done_cnt;
      rx_drv  = 1'b0;
      step(4 * DV);
      rx_drv  = 1'b1;
      step(200);
      check("glitch no done", rx_done_cnt - rx_cnt0, 0);
      check("glitch o_rx held", o_rx, 8'h4B);

      // Framing error, then a clean frame clears the flag.
      rx_cnt0 = rx_done_cnt;
      send_frame(8'hA5, 1'b0, 1'b0);
      check("frame err done count", rx_done_cnt - rx_cnt0, 1);
      check("frame err o_rx", o_rx, 8'hA5);
      check("frame err flag", o_frame_err, 1'b1);
      send_frame(8'hC3, 1'b1, 1'b0);
      check("clean o_rx", o_rx, 8'hC3);
      check("clean frame_err", o_frame_err, 1'b0);

`ifdef UART_PARITY_EN
      send_frame(8'h07, 1'b1, 1'b1);
      check("bad parity o_rx", o_rx, 8'h07);
      check("bad parity flag", o_parity_err, 1'b1);
      send_frame(8'h07, 1'b1, 1'b0);
      check("good parity flag", o_parity_err, 1'b0);
`endif

      // Reset in the middle of data bit 2 of a loopback frame.
      loop_en = 1'b1;
      step(2);
      tx_send(8'hF0);
      step(3 * BIT_CYC + BIT_CYC / 2);
      check("busy mid frame", o_tx_busy, 1'b1);
      check("line mid frame", o_tx, 1'b0);
      tx_cnt0 = tx_done_cnt;
      rx_cnt0 = rx_done_cnt;
      rst_n   = 1'b0;
      #1;
      check("o_tx on reset", o_tx, 1'b1);
      check("busy on reset", o_tx_busy, 1'b0);
      step(3);
      rst_n = 1'b1;
      step(40);
      check("no tx done after abort", tx_done_cnt - tx_cnt0, 0);
      check("no rx done after abort", rx_done_cnt - rx_cnt0, 0);
      tx_send(8'h5A);
      wait_rx_done("rx done 5A");
      check("rx 5A", o_rx, 8'h5A);
      check("rx 5A frame_err", o_frame_err, 1'b0);
      wait_tx_done("tx done 5A");
      step(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
